// File: rtl/i2c_rx_burst_controller.sv
// I2C master burst receive engine: shifts in bytes MSB first, ACKs all but the last, streams them out on valid/ready.
// Optional SCL stretch timeout is built when I2C_RX_STRETCH_TIMEOUT_EN is defined.
module i2c_rx_burst_controller #(
   parameter int unsigned LEN_WIDTH = 8
`ifdef I2C_RX_STRETCH_TIMEOUT_EN
   , parameter int unsigned STRETCH_TIMEOUT = 1024
`endif
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_tick,
   input  logic                 i_rx_start,
   input  logic [LEN_WIDTH-1:0] i_rx_len,
   input  logic                 i_abort,
   input  logic                 i_scl,
   input  logic                 i_sda,
   input  logic                 i_rx_ready,
   output logic                 o_rx_valid,
   output logic [7:0]           o_rx_data,
   output logic                 o_rx_last,
   output logic [LEN_WIDTH-1:0] o_byte_count,
   output logic                 o_busy,
   output logic                 o_rx_done,
   output logic                 o_rx_error,
   output logic                 o_sda,
   output logic                 o_scl,
   output logic                 o_sda_disable,
   output logic                 o_scl_disable
);

   typedef enum logic [1:0] {ST_IDLE, ST_BIT, ST_HOLD, ST_ACK} state_t;

   state_t               r_state;
   logic [1:0]           r_step;
   logic [2:0]           r_bit_cnt;
   logic [LEN_WIDTH-1:0] r_len;
   logic [LEN_WIDTH-1:0] r_byte_count;
   logic [7:0]           r_shift;
   logic [7:0]           r_rx_data;
   logic                 r_rx_valid;
   logic                 r_rx_last;
   logic                 r_rx_done;
   logic                 r_rx_error;
   logic                 r_sda;
   logic                 r_scl;

   logic                 w_bus_phase;
   logic [LEN_WIDTH-1:0] w_count_inc;

`ifdef I2C_RX_STRETCH_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(STRETCH_TIMEOUT + 1);
   logic [TO_W-1:0] r_to_cnt;
   logic            w_to_expire;
   assign w_to_expire = (r_to_cnt == TO_W'(STRETCH_TIMEOUT - 1));
`endif

   assign w_bus_phase   = (r_state == ST_BIT) || (r_state == ST_ACK);
   assign w_count_inc   = r_byte_count + LEN_WIDTH'(1);

   assign o_scl_disable = w_bus_phase && ((r_step == 2'd1) || (r_step == 2'd2));
   assign o_sda_disable = (r_state != ST_ACK);
   assign o_busy        = (r_state != ST_IDLE);
   assign o_rx_valid    = r_rx_valid;
   assign o_rx_data     = r_rx_data;
   assign o_rx_last     = r_rx_last;
   assign o_byte_count  = r_byte_count;
   assign o_rx_done     = r_rx_done;
   assign o_rx_error    = r_rx_error;
   assign o_sda         = r_sda;
   assign o_scl         = r_scl;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_step       <= '0;
         r_bit_cnt    <= '0;
         r_len        <= '0;
         r_byte_count <= '0;
         r_shift      <= '0;
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_rx_last    <= 1'b0;
         r_rx_done    <= 1'b0;
         r_rx_error   <= 1'b0;
         r_sda        <= 1'b1;
         r_scl        <= 1'b0;
`ifdef I2C_RX_STRETCH_TIMEOUT_EN
         r_to_cnt     <= '0;
`endif
      end else begin
         r_rx_done  <= 1'b0;
         r_rx_error <= 1'b0;
         if (i_abort && (r_state != ST_IDLE)) begin
            r_state    <= ST_IDLE;
            r_step     <= '0;
            r_rx_valid <= 1'b0;
            r_sda      <= 1'b1;
            r_scl      <= 1'b0;
`ifdef I2C_RX_STRETCH_TIMEOUT_EN
            r_to_cnt   <= '0;
`endif
         end else if (w_bus_phase && (r_step == 2'd1)) begin
            // Step 1 is shared by BIT and ACK: wait for the slave to let SCL rise
            if (i_tick) begin
               if (i_scl) begin
                  r_step <= 2'd2;
`ifdef I2C_RX_STRETCH_TIMEOUT_EN
                  r_to_cnt <= '0;
               end else if (w_to_expire) begin
                  r_state    <= ST_IDLE;
                  r_step     <= '0;
                  r_to_cnt   <= '0;
                  r_rx_error <= 1'b1;
                  r_rx_valid <= 1'b0;
                  r_sda      <= 1'b1;
                  r_scl      <= 1'b0;
               end else begin
                  r_to_cnt <= r_to_cnt + TO_W'(1);
`endif
               end
            end
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (i_rx_start && !i_abort) begin
                     if (i_rx_len == '0) begin
                        r_rx_error <= 1'b1;
                     end else begin
                        r_len        <= i_rx_len;
                        r_byte_count <= '0;
                        r_bit_cnt    <= '0;
                        r_step       <= '0;
                        r_state      <= ST_BIT;
                     end
                  end
               end
               ST_BIT: begin
                  if (i_tick) begin
                     case (r_step)
                        2'd0: begin
                           r_scl  <= 1'b1;
                           r_step <= 2'd1;
                        end
                        2'd2: begin
                           r_shift <= {r_shift[6:0], i_sda};
                           r_scl   <= 1'b0;
                           r_step  <= 2'd3;
                        end
                        2'd3: begin
                           r_step    <= 2'd0;
                           r_bit_cnt <= r_bit_cnt + 3'd1;
                           if (r_bit_cnt == 3'd7) begin
                              r_state    <= ST_HOLD;
                              r_rx_data  <= r_shift;
                              r_rx_valid <= 1'b1;
                              r_rx_last  <= (w_count_inc == r_len);
                           end
                        end
                        default: ;
                     endcase
                  end
               end
               ST_HOLD: begin
                  if (r_rx_valid && i_rx_ready) begin
                     r_rx_valid   <= 1'b0;
                     r_byte_count <= w_count_inc;
                     r_step       <= 2'd0;
                     r_state      <= ST_ACK;
                  end
               end
               ST_ACK: begin
                  if (i_tick) begin
                     case (r_step)
                        2'd0: begin
                           r_scl  <= 1'b1;
                           r_sda  <= r_rx_last;
                           r_step <= 2'd1;
                        end
                        2'd2: begin
                           r_scl  <= 1'b0;
                           r_step <= 2'd3;
                        end
                        2'd3: begin
                           r_step <= 2'd0;
                           if (r_rx_last) begin
                              r_rx_done <= 1'b1;
                              r_sda     <= 1'b1;
                              r_state   <= ST_IDLE;
                           end else begin
                              r_state <= ST_BIT;
                           end
                        end
                        default: ;
                     endcase
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_rx_burst_controller.sv
// Randomised bench for i2c_rx_burst_controller with a bus-level slave and consumer model.
module tb_i2c_rx_burst_controller;

   localparam int LW = 8;
   localparam logic [24:0] RESET_OUTS = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_tick;
   logic          i_rx_start;
   logic [LW-1:0] i_rx_len;
   logic          i_abort;
   logic          i_scl;
   logic          i_sda;
   logic          i_rx_ready;
   logic          o_rx_valid;
   logic [7:0]    o_rx_data;
   logic          o_rx_last;
   logic [LW-1:0] o_byte_count;
   logic          o_busy;
   logic          o_rx_done;
   logic          o_rx_error;
   logic          o_sda;
   logic          o_scl;
   logic          o_sda_disable;
   logic          o_scl_disable;

   int vectors = 0;
   int miscompares = 0;

   // Slave model state: bytes to send, position, and SCL hold controls
   logic [7:0] tx_bytes[$];
   int   byte_idx = 0;
   int   bit_idx = 0;
   int   stretch_bit = -1;
   int   hold_cnt = 0;
   logic stuck_low = 1'b0;
   logic held_snap = 1'b0;
   logic scl_prev = 1'b0;
   logic w_hold;

   // Monitor state
   logic [7:0] beat_data[$];
   logic       beat_last[$];
   int         beat_tick[$];
   logic       acks[$];
   int   done_cnt = 0;
   int   err_cnt = 0;
   int   tick_total = 0;
   int   start_tick = 0;
   int   err_tick = 0;
   int   tick_div = 0;
   logic valid_prev = 1'b0;
   logic busy_prev = 1'b0;

   i2c_rx_burst_controller #(
      .LEN_WIDTH(LW)
`ifdef I2C_RX_STRETCH_TIMEOUT_EN
      , .STRETCH_TIMEOUT(16)
`endif
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_tick(i_tick), .i_rx_start(i_rx_start),
      .i_rx_len(i_rx_len), .i_abort(i_abort), .i_scl(i_scl), .i_sda(i_sda),
      .i_rx_ready(i_rx_ready), .o_rx_valid(o_rx_valid), .o_rx_data(o_rx_data),
      .o_rx_last(o_rx_last), .o_byte_count(o_byte_count), .o_busy(o_busy),
      .o_rx_done(o_rx_done), .o_rx_error(o_rx_error), .o_sda(o_sda), .o_scl(o_scl),
      .o_sda_disable(o_sda_disable), .o_scl_disable(o_scl_disable)
   );

   always #5 clk = ~clk;

   // Bus SCL: driven by master unless released, then pulled high unless the slave holds it
   assign w_hold = stuck_low || ((hold_cnt > 0) && (stretch_bit == bit_idx) && o_sda_disable);
   assign i_scl  = o_scl_disable ? !w_hold : o_scl;

   always @(negedge clk) begin
      logic [7:0] b;
      if (i_scl && !scl_prev) begin
         if (o_sda_disable) begin
            b = (byte_idx < tx_bytes.size()) ? tx_bytes[byte_idx] : 8'hFF;
            i_sda = b[7 - bit_idx];
         end else begin
            acks.push_back(o_sda);
         end
      end
      if (!i_scl && scl_prev && o_sda_disable) begin
         bit_idx++;
         if (bit_idx == 8) begin
            bit_idx = 0;
            byte_idx++;
         end
      end
      scl_prev = i_scl;
      if (i_tick) begin
         tick_total++;
         if (held_snap && hold_cnt > 0) hold_cnt--;
      end
      held_snap = o_scl_disable && (hold_cnt > 0) && (stretch_bit == bit_idx) && o_sda_disable;
      if (o_busy && !busy_prev) start_tick = tick_total;
      busy_prev = o_busy;
      if (o_rx_valid && !valid_prev) begin
         beat_data.push_back(o_rx_data);
         beat_last.push_back(o_rx_last);
         beat_tick.push_back(tick_total - start_tick);
      end
      valid_prev = o_rx_valid;
      if (o_rx_done) done_cnt++;
      if (o_rx_error) begin
         err_cnt++;
         err_tick = tick_total - start_tick;
      end
      tick_div = (tick_div + 1) % 4;
      i_tick = (tick_div == 0);
   end

   function automatic logic [24:0] outs();
      return {o_sda, o_scl, o_rx_valid, o_rx_last, o_busy, o_rx_done, o_rx_error,
              o_scl_disable, o_sda_disable, o_rx_data, o_byte_count};
   endfunction

   task automatic slave_reset();
      tx_bytes.delete();
      byte_idx = 0;
      bit_idx = 0;
      i_sda = 1'b1;
   endtask

   task automatic clear_mon();
      beat_data.delete();
      beat_last.delete();
      beat_tick.delete();
      acks.delete();
      done_cnt = 0;
      err_cnt = 0;
   endtask

   task automatic start_burst(input logic [LW-1:0] len);
      @(negedge clk);
      i_rx_len = len;
      i_rx_start = 1'b1;
      @(negedge clk);
      i_rx_start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!o_busy) begin
            ok = 1'b1;
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (outs() !== RESET_OUTS) begin
         miscompares++;
         $display("FAIL reset_outs: got %h expected %h", outs(), RESET_OUTS);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_burst3();
      logic ok;
      slave_reset();
      tx_bytes = '{8'hA5, 8'h3C, 8'hFF};
      clear_mon();
      i_rx_ready = 1'b1;
      start_burst(3);
      wait_idle(3000, ok);
      vectors++;
      if (ok !== 1'b1) begin miscompares++; $display("FAIL burst3_finish: got busy, expected idle"); end
      vectors++;
      if (beat_data.size() !== 3) begin
         miscompares++; $display("FAIL burst3_beats: got %0d expected 3", beat_data.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({beat_data[i], beat_last[i]} !== {tx_bytes[i], (i == 2)}) begin
               miscompares++;
               $display("FAIL burst3_beat%0d: got %h/%b expected %h/%b", i, beat_data[i], beat_last[i], tx_bytes[i], (i == 2));
            end
         end
         vectors++;
         if (beat_tick[0] !== 32) begin miscompares++; $display("FAIL burst3_latency: got %0d ticks expected 32", beat_tick[0]); end
      end
      vectors++;
      if (acks.size() !== 3 || acks[0] !== 1'b0 || acks[1] !== 1'b0 || acks[2] !== 1'b1) begin
         miscompares++; $display("FAIL burst3_acks: got %p expected 0,0,1", acks);
      end
      vectors++;
      if ({done_cnt, err_cnt} !== {32'd1, 32'd0}) begin
         miscompares++; $display("FAIL burst3_done: got done=%0d err=%0d expected 1/0", done_cnt, err_cnt);
      end
      vectors++;
      if (o_byte_count !== 8'd3 || o_sda !== 1'b1) begin
         miscompares++; $display("FAIL burst3_count: got %0d sda=%b expected 3 sda=1", o_byte_count, o_sda);
      end
   endtask

   task automatic test_consumer_stall();
      logic ok;
      slave_reset();
      tx_bytes.push_back(8'($urandom));
      tx_bytes.push_back(8'($urandom));
      clear_mon();
      i_rx_ready = 1'b0;
      start_burst(2);
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (o_rx_valid) begin ok = 1'b1; break; end
      end
      vectors++;
      if (ok !== 1'b1) begin miscompares++; $display("FAIL stall_valid: got no valid, expected valid"); end
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         vectors++;
         if ({o_scl, o_rx_valid, o_rx_data, o_sda_disable, o_byte_count} !== {1'b0, 1'b1, tx_bytes[0], 1'b1, 8'd0}) begin
            miscompares++;
            $display("FAIL stall_hold%0d: got scl=%b v=%b d=%h sdadis=%b cnt=%0d expected 0/1/%h/1/0",
                     i, o_scl, o_rx_valid, o_rx_data, o_sda_disable, o_byte_count, tx_bytes[0]);
         end
      end
      vectors++;
      if (acks.size() !== 0) begin miscompares++; $display("FAIL stall_no_ack: got %0d acks expected 0", acks.size()); end
      i_rx_ready = 1'b1;
      wait_idle(3000, ok);
      vectors++;
      if (ok !== 1'b1 || beat_data.size() !== 2 || beat_data[1] !== tx_bytes[1] || beat_last[1] !== 1'b1) begin
         miscompares++; $display("FAIL stall_byte2: got beats=%0d expected 2 with %h last", beat_data.size(), tx_bytes[1]);
      end
      vectors++;
      if (acks.size() !== 2 || acks[0] !== 1'b0 || acks[1] !== 1'b1 || o_byte_count !== 8'd2) begin
         miscompares++; $display("FAIL stall_acks: got %p cnt=%0d expected 0,1 cnt=2", acks, o_byte_count);
      end
   endtask

   task automatic test_zero_len();
      clear_mon();
      start_burst(0);
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (o_busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy%0d: got %b expected 0", i, o_busy); end
         @(negedge clk);
      end
      vectors++;
      if ({err_cnt, done_cnt} !== {32'd1, 32'd0}) begin
         miscompares++; $display("FAIL zero_error: got err=%0d done=%0d expected 1/0", err_cnt, done_cnt);
      end
   endtask

   task automatic test_slave_stretch();
      logic ok;
      slave_reset();
      tx_bytes.push_back(8'($urandom));
      clear_mon();
      stretch_bit = 3;
      hold_cnt = 5;
      i_rx_ready = 1'b1;
      start_burst(1);
      wait_idle(3000, ok);
      stretch_bit = -1;
      vectors++;
      if (ok !== 1'b1 || beat_data.size() !== 1) begin
         miscompares++; $display("FAIL stretch_beats: got %0d expected 1", beat_data.size());
      end else begin
         vectors++;
         if (beat_data[0] !== tx_bytes[0]) begin miscompares++; $display("FAIL stretch_data: got %h expected %h", beat_data[0], tx_bytes[0]); end
         vectors++;
         if (beat_tick[0] !== 37) begin miscompares++; $display("FAIL stretch_latency: got %0d expected 37", beat_tick[0]); end
      end
      vectors++;
      if ({err_cnt, done_cnt, hold_cnt} !== {32'd0, 32'd1, 32'd0}) begin
         miscompares++; $display("FAIL stretch_status: got err=%0d done=%0d hold=%0d expected 0/1/0", err_cnt, done_cnt, hold_cnt);
      end
   endtask

   task automatic test_stretch_timeout();
      logic ok;
      slave_reset();
      tx_bytes.push_back(8'($urandom));
      clear_mon();
      stuck_low = 1'b1;
      start_burst(LW'($urandom_range(1, 3)));
`ifdef I2C_RX_STRETCH_TIMEOUT_EN
      wait_idle(500, ok);
      vectors++;
      if (ok !== 1'b1) begin miscompares++; $display("FAIL timeout_idle: got busy expected idle"); end
      vectors++;
      if ({err_cnt, err_tick, done_cnt} !== {32'd1, 32'd17, 32'd0}) begin
         miscompares++; $display("FAIL timeout_error: got err=%0d at tick %0d done=%0d expected 1 at 17, 0", err_cnt, err_tick, done_cnt);
      end
      vectors++;
      if ({o_sda, o_scl, o_rx_valid} !== 3'b100) begin
         miscompares++; $display("FAIL timeout_lines: got %b expected 100", {o_sda, o_scl, o_rx_valid});
      end
`else
      repeat (160) @(negedge clk);
      vectors++;
      if ({o_busy, o_scl_disable, err_cnt} !== {1'b1, 1'b1, 32'd0}) begin
         miscompares++; $display("FAIL wait_forever: got busy=%b scldis=%b err=%0d expected 1/1/0", o_busy, o_scl_disable, err_cnt);
      end
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
      wait_idle(10, ok);
      vectors++;
      if (ok !== 1'b1) begin miscompares++; $display("FAIL wait_abort: got busy expected idle"); end
`endif
      stuck_low = 1'b0;
   endtask

   task automatic test_abort_and_reset();
      logic ok;
      slave_reset();
      for (int i = 0; i < 3; i++) tx_bytes.push_back(8'($urandom));
      clear_mon();
      i_rx_ready = 1'b1;
      start_burst(3);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (byte_idx == 1 && bit_idx == 4 && o_scl_disable) begin ok = 1'b1; break; end
      end
      vectors++;
      if (ok !== 1'b1) begin miscompares++; $display("FAIL abort_reach_bit5: got no bit 5, expected it"); end
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
      vectors++;
      if ({o_busy, o_rx_valid, o_sda, o_scl, o_byte_count} !== {4'b0010, 8'd1}) begin
         miscompares++; $display("FAIL abort_state: got busy=%b v=%b sda=%b scl=%b cnt=%0d expected 0/0/1/0/1",
                                 o_busy, o_rx_valid, o_sda, o_scl, o_byte_count);
      end
      repeat (20) @(negedge clk);
      vectors++;
      if ({done_cnt, err_cnt, o_busy} !== {32'd0, 32'd0, 1'b0}) begin
         miscompares++; $display("FAIL abort_quiet: got done=%0d err=%0d busy=%b expected 0/0/0", done_cnt, err_cnt, o_busy);
      end

      // abort on the handshake cycle must not count the byte
      slave_reset();
      tx_bytes = '{8'h81, 8'h42};
      clear_mon();
      i_rx_ready = 1'b0;
      start_burst(2);
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (o_rx_valid) begin ok = 1'b1; break; end
      end
      i_rx_ready = 1'b1;
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
      i_rx_ready = 1'b0;
      vectors++;
      if ({ok, o_busy, o_rx_valid, o_byte_count} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
         miscompares++; $display("FAIL abort_handshake: got seen=%b busy=%b v=%b cnt=%0d expected 1/0/0/0", ok, o_busy, o_rx_valid, o_byte_count);
      end

      // abort together with start in IDLE ignores the start
      @(negedge clk);
      i_rx_len = 8'd2;
      i_rx_start = 1'b1;
      i_abort = 1'b1;
      @(negedge clk);
      i_rx_start = 1'b0;
      i_abort = 1'b0;
      vectors++;
      if (o_busy !== 1'b0) begin miscompares++; $display("FAIL abort_start_idle: got busy=%b expected 0", o_busy); end

      // asynchronous reset mid-burst
      slave_reset();
      for (int i = 0; i < 3; i++) tx_bytes.push_back(8'($urandom));
      clear_mon();
      i_rx_ready = 1'b1;
      start_burst(3);
      repeat (170) @(negedge clk);
      vectors++;
      if (o_busy !== 1'b1 || o_byte_count !== 8'd1) begin
         miscompares++; $display("FAIL reset_precond: got busy=%b cnt=%0d expected 1/1", o_busy, o_byte_count);
      end
      #1 rst_n = 1'b0;
      #1;
      vectors++;
      if (outs() !== RESET_OUTS) begin
         miscompares++; $display("FAIL reset_async: got %h expected %h", outs(), RESET_OUTS);
      end
      @(negedge clk);
      rst_n = 1'b1;
      slave_reset();
      @(negedge clk);
   endtask

   task automatic test_random();
      logic ok;
      int   len;
      for (int b = 0; b < 4; b++) begin
         len = $urandom_range(1, 4);
         slave_reset();
         for (int i = 0; i < len; i++) tx_bytes.push_back(8'($urandom));
         clear_mon();
         i_rx_ready = 1'b0;
         start_burst(LW'(len));
         ok = 1'b0;
         for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            i_rx_ready = 1'($urandom_range(0, 1));
            i_rx_start = (c == 30);
            i_rx_len = LW'(len + 2);
            if (!o_busy) begin ok = 1'b1; break; end
         end
         i_rx_start = 1'b0;
         @(negedge clk);
         vectors++;
         if (ok !== 1'b1 || beat_data.size() !== len) begin
            miscompares++; $display("FAIL rand%0d_beats: got %0d expected %0d", b, beat_data.size(), len);
         end else begin
            for (int i = 0; i < len; i++) begin
               vectors++;
               if ({beat_data[i], beat_last[i], acks[i]} !== {tx_bytes[i], (i == len - 1), (i == len - 1)}) begin
                  miscompares++;
                  $display("FAIL rand%0d_beat%0d: got %h/%b ack=%b expected %h/%b", b, i, beat_data[i], beat_last[i], acks[i], tx_bytes[i], (i == len - 1));
               end
            end
         end
         vectors++;
         if ({o_byte_count, done_cnt, err_cnt} !== {LW'(len), 32'd1, 32'd0}) begin
            miscompares++; $display("FAIL rand%0d_count: got cnt=%0d done=%0d err=%0d expected %0d/1/0", b, o_byte_count, done_cnt, err_cnt, len);
         end
      end
      i_rx_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic ok;
      slave_reset();
      tx_bytes = '{8'h5A, 8'hC3};
      clear_mon();
      i_rx_ready = 1'b1;
      start_burst(1);
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (o_rx_done) begin ok = 1'b1; break; end
      end
      i_rx_len = 8'd1;
      i_rx_start = 1'b1;
      @(negedge clk);
      i_rx_start = 1'b0;
      vectors++;
      if ({ok, o_busy} !== 2'b11) begin
         miscompares++; $display("FAIL b2b_accept: got done_seen=%b busy=%b expected 1/1", ok, o_busy);
      end
      wait_idle(2000, ok);
      vectors++;
      if (ok !== 1'b1 || beat_data.size() !== 2 || beat_data[0] !== 8'h5A || beat_data[1] !== 8'hC3 || done_cnt !== 2) begin
         miscompares++; $display("FAIL b2b_data: got beats=%0d done=%0d expected 5A,C3 done=2", beat_data.size(), done_cnt);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      i_tick = 1'b0;
      i_rx_start = 1'b0;
      i_rx_len = '0;
      i_abort = 1'b0;
      i_sda = 1'b1;
      i_rx_ready = 1'b0;
      test_reset();
      test_burst3();
      test_consumer_stall();
      test_zero_len();
      test_slave_stretch();
      test_stretch_timeout();
      test_abort_and_reset();
      test_random();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: got no completion, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
